// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide unit: ALU function codes,
// sequencer state encoding and decode helpers for the four divide ops.
package div_ctrl_pkg;

  // ALU function codes of the divide group (mirror of sys_defs.vh)
  localparam logic [4:0] ALU_DIV  = 5'h0C;
  localparam logic [4:0] ALU_DIVU = 5'h0D;
  localparam logic [4:0] ALU_REM  = 5'h0E;
  localparam logic [4:0] ALU_REMU = 5'h0F;

  // Quotient returned for a divide by zero
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // DIV and REM treat their operands as two's complement
  function automatic logic func_is_signed(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic func_sel_rem(input logic [4:0] func);
    return (func == ALU_REM) || (func == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, try to
// subtract the divisor, keep the difference and set the quotient LSB when it
// does not go negative. Purely combinational so a radix-4 variant can chain two.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit above the shifted remainder carries the trial sign.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift, trial subtract and restore-or-keep select
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {2'b00, dvs_i};
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    rem_o   = shifted[WIDTH:0];
    if (!trial[WIDTH+1]) begin
      rem_o    = trial[WIDTH:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) beside the EX stage.
// Holds the pipeline with div_stall while iterating and pulses div_done for
// the single cycle in which div_result is presented to EX.
//
// state | meaning
// IDLE  | waiting for div_req; accepts operands or takes the fast path
// BUSY  | one restoring step per cycle, WIDTH cycles
// FIX   | sign correction and quotient/remainder select into result
// DONE  | result presented, div_done high, stall released
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req,
  input  logic [4:0]       div_func,
  input  logic [WIDTH-1:0] div_opa,
  input  logic [WIDTH-1:0] div_opb,
  input  logic             div_flush,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             sel_rem_q, sel_rem_d;

  logic             acc_signed;
  logic             acc_rem;
  logic [WIDTH-1:0] opa_mag;
  logic [WIDTH-1:0] opb_mag;
  logic             by_zero;
  logic             overflow;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Acceptance decode; a magnitude of MIN_NEG stays 2^(WIDTH-1) read unsigned
  always_comb begin
    acc_signed = func_is_signed(div_func);
    acc_rem    = func_sel_rem(div_func);
    opa_mag    = (acc_signed && div_opa[WIDTH-1]) ? -div_opa : div_opa;
    opb_mag    = (acc_signed && div_opb[WIDTH-1]) ? -div_opb : div_opb;
    by_zero    = (div_opb == '0);
    overflow   = acc_signed && (div_opa == MIN_NEG) && (div_opb == '1);
  end

  // Next-state and datapath; flush overrides everything and returns to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    if (div_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_req) begin
            sel_rem_d = acc_rem;
            neg_quo_d = acc_signed && (div_opa[WIDTH-1] ^ div_opb[WIDTH-1]);
            neg_rem_d = acc_signed && div_opa[WIDTH-1];
            quo_d     = opa_mag;
            dvs_d     = opb_mag;
            rem_d     = '0;
            if (by_zero) begin
              result_d = acc_rem ? div_opa : {WIDTH{1'b1}};
              state_d  = DONE;
            end else if (overflow) begin
              result_d = acc_rem ? '0 : MIN_NEG;
              state_d  = DONE;
            end else begin
              cnt_d   = CW'(WIDTH);
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          if (sel_rem_q) result_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          else           result_d = neg_quo_q ? -quo_q : quo_q;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  // Stall covers the request cycle through FIX so the pipeline advances in
  // the DONE cycle; held low in reset and during a flush.
  always_comb begin
    div_stall  = div_req && (state_q != DONE) && !div_flush && !rst;
    div_done   = (state_q == DONE) && !div_flush;
    div_result = result_q;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: stimulus pushes hand-computed results into a
// queue, a negedge monitor pops and compares on every div_done pulse.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_req = 1'b0;
  logic [4:0]   div_func = ALU_DIVU;
  logic [W-1:0] div_opa = '0;
  logic [W-1:0] div_opb = '0;
  logic         div_flush = 1'b0;
  logic         div_stall;
  logic         div_done;
  logic [W-1:0] div_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  div_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_req    (div_req),
    .div_func   (div_func),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .div_flush  (div_flush),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (div_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result %0h, expected no done", div_result);
      end else begin
        check("result", div_result, exp_q.pop_front());
      end
    end
  end

  // Issue one op at posedge+1 with state IDLE; count stall cycles until done
  task automatic run_op(input string name, input logic [4:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int exp_stall, input bit drop);
    int  stall_cnt;
    int  cyc;
    bit  seen;
    stall_cnt = 0;
    cyc       = 0;
    seen      = 1'b0;
    div_req   = 1'b1;
    div_func  = f;
    div_opa   = a;
    div_opb   = b;
    exp_q.push_back(exp);
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (div_stall) stall_cnt++;
      if (div_done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no done in %0d cycles, expected done", name, cyc);
    end
    check({name, " stall"}, stall_cnt, exp_stall);
    check({name, " latency"}, cyc, exp_stall + 1);
    @(posedge clk); #1;
    if (drop) begin
      div_req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request pending: stall must still be gated off
    div_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rst stall", div_stall, 1'b0);
    check("rst done", div_done, 1'b0);
    check("rst result", div_result, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    div_req = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7",  ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 1);
    run_op("remu_100_7",  ALU_REMU, 32'd100, 32'd7, 32'd2,  34, 1);
    run_op("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1);
    run_op("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1);
    run_op("div_7_m2",    ALU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1);
    run_op("rem_7_m2",    ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1);
    run_op("div_min_2",   ALU_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 34, 1);
    run_op("rem_100_min", ALU_REM,  32'd100, 32'h8000_0000, 32'd100, 34, 1);
    run_op("divu_max_1",  ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1);
    run_op("div_5_0",     ALU_DIV,  32'd5, 32'd0, DIV_ZERO_Q, 1, 1);
    run_op("remu_5_0",    ALU_REMU, 32'd5, 32'd0, 32'd5, 1, 1);
    run_op("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    run_op("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);

    // Flush in BUSY cycle 10: no done, stall dropped, unit back in IDLE
    div_req  = 1'b1;
    div_func = ALU_DIVU;
    div_opa  = 32'd1000;
    div_opb  = 32'd3;
    repeat (10) @(posedge clk);
    #1 div_flush = 1'b1;
    @(negedge clk);
    check("flush stall", div_stall, 1'b0);
    check("flush done", div_done, 1'b0);
    @(posedge clk); #1;
    div_flush = 1'b0;
    div_req   = 1'b0;
    repeat (40) @(negedge clk);
    check("flush result held", div_result, 32'd0);
    @(posedge clk); #1;
    run_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 34, 1);

    // Flush in the DONE cycle suppresses the pulse
    div_req  = 1'b1;
    div_func = ALU_DIVU;
    div_opa  = 32'd8;
    div_opb  = 32'd2;
    repeat (34) @(posedge clk);
    #1 div_flush = 1'b1;
    @(negedge clk);
    check("flush_done done", div_done, 1'b0);
    check("flush_done stall", div_stall, 1'b0);
    @(posedge clk); #1;
    div_flush = 1'b0;
    div_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with req held across DONE
    run_op("b2b_divu_8_2", ALU_DIVU, 32'd8, 32'd2, 32'd4, 34, 0);
    run_op("b2b_remu_9_4", ALU_REMU, 32'd9, 32'd4, 32'd1, 34, 1);

    // Reset mid-BUSY clears outputs at once
    div_req  = 1'b1;
    div_func = ALU_DIVU;
    div_opa  = 32'd1000;
    div_opb  = 32'd3;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst stall", div_stall, 1'b0);
    check("midrst done", div_done, 1'b0);
    check("midrst result", div_result, '0);
    @(posedge clk); #1;
    rst     = 1'b0;
    div_req = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 1);

    repeat (5) @(negedge clk);
    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle integer divide unit with its sequencing FSM. Executes the RV32M DIV, DIVU, REM and REMU operations that the single-cycle EX ALU does not implement.
- Sits beside the EX stage and receives the same selected operands (opa, opb) and ALU function code.
- Holds the pipeline with a stall while iterating. Returns the 32-bit result, which EX muxes onto its ALU result when div_done is high.
- Radix-2 restoring division, one quotient bit per cycle, with fast paths for the special cases.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration counter is $clog2(WIDTH)+1 bits wide.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- div_req  in  1  ID_EX_vld AND alu_func is one of the four divide codes; held steady while div_stall=1
- div_func  in  5  ALU function code (`ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU from sys_defs.vh)
- div_opa  in  WIDTH  dividend (forwarded opa)
- div_opb  in  WIDTH  divisor (forwarded opb)
- div_flush  in  1  kill the in-flight operation (branch taken / pipeline flush)
- div_stall  out  1  freeze the IF/ID/EX pipeline registers
- div_done  out  1  one-cycle pulse; div_result is valid in this cycle
- div_result  out  WIDTH  quotient or remainder

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counter, quotient, remainder and divisor registers = 0.
  - div_stall=0, div_done=0, div_result=0.
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE:
  - On div_req=1 and div_flush=0, latch the operands, func, signedness (DIV/REM signed) and the result select (REM/REMU select the remainder).
  - Signed ops store operand magnitudes and record sign_q = opa[31]^opb[31] and sign_r = opa[31].
  - If opb==0 or (signed and opa==32'h8000_0000 and opb==32'hFFFF_FFFF), load the special result and go to DONE.
  - Otherwise load counter=WIDTH and go to BUSY.
- BUSY:
  - Each cycle: shift {rem,quo} left by 1; trial = rem - divisor; if trial is non-negative, rem=trial and quo[0]=1.
  - Decrement the counter. When it reaches 0, go to FIX.
- FIX: negate quo if sign_q, negate rem if sign_r (signed ops only). Select quo or rem into the result register. Go to DONE.
- DONE: div_done=1 for exactly one cycle, then go to IDLE.
- Special results (RISC-V spec):
  - Divide by zero: DIV/DIVU give 32'hFFFF_FFFF; REM/REMU give the dividend.
  - Signed overflow: DIV gives 32'h8000_0000; REM gives 0.
- div_stall (combinational) = div_req AND state != DONE. This includes the IDLE acceptance cycle. Stall is therefore high from the request cycle through FIX and low in the DONE cycle, so the pipeline advances exactly when the result is presented.
- Latency:
  - Normal operation: request cycle (IDLE), then 32 BUSY cycles, then FIX, then DONE. div_done comes 34 cycles after the accept edge, and the stall lasts 34 cycles.
  - Special case: div_done on the cycle after the accept.
- div_req=1 in the DONE cycle belongs to the completing op and is not re-accepted. A new request is accepted only from IDLE, at the earliest the cycle after DONE.
- div_flush has priority in every state:
  - Next state is IDLE and no div_done is produced.
  - A flush in the DONE cycle also suppresses div_done.
  - div_stall is forced to 0 while div_flush=1.
- Operands and div_func are sampled only at acceptance. Input changes during BUSY are ignored.
- div_result holds its value until the next FIX or special-case load.
- The remainder register is WIDTH+1 bits so the trial subtraction's sign bit is explicit.
- The divisor magnitude of 32'h8000_0000 must be handled as unsigned 2^31.

Decomposition:
- Shared package / sys_defs.vh:
  - The existing `ALU_DIV/`ALU_DIVU/`ALU_REM/`ALU_REMU codes.
  - The new div_state_t enum (IDLE, BUSY, FIX, DONE).
  - The DIV_ZERO_Q constant (all ones).
- One natural sub-module: div_iter_step, the combinational shift/trial-subtract/select of one radix-2 step, reusable if a radix-4 version unrolls it twice.
- The FSM, counter and sign fix-up stay in div_ctrl.

Test Plan:
- DIVU 100 / 7, req held -> stall high for 34 cycles; div_done pulse with div_result=14. REMU same operands -> 2.
- DIV -7 (32'hFFFF_FFF9) / 2 -> 32'hFFFF_FFFD (-3). REM same operands -> 32'hFFFF_FFFF (-1).
- DIV 5 / 0 -> div_result=32'hFFFF_FFFF with done on the cycle after accept. REMU 5 / 0 -> 5.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000. REM same operands -> 0. Both via the fast path.
- Start DIVU 1000/3; assert div_flush in BUSY cycle 10 -> state IDLE next cycle, stall 0, no div_done. A fresh DIVU 9/3 then returns 3.
- Back-to-back DIVU 8/2 then REMU 9/4, req held across DONE -> two done pulses with results 4 then 1. The second op is not accepted until the cycle after the first DONE. Assert rst mid-BUSY -> all outputs 0 immediately.
